atanh_bfloat19_pipe: RTL and testbench
======================================

ATANH_BFLOAT19_PIPE -- requirements
Module: atanh_bfloat19_pipe

Interface
REQ-001 Parameter: LUT_FILE, "atanh_4.hex", 1024 x 12-bit table; entry i = round(atanh(i/1024)*512), half rounds up.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: enable  input  1  global clock enable; low freezes every register.
REQ-005 Port: in_valid  input  1  num_entrada carries a sample this cycle.
REQ-006 Port: num_entrada  input  19  bfloat19 operand: sign[18], exponent[17:10] (bias 127), mantissa[9:0].
REQ-007 Port: out_valid  output  1  num_salida carries a result.
REQ-008 Port: num_salida  output  19  bfloat19 atanh(num_entrada).
REQ-009 Port: domain_err  output  1  result is NaN because the operand is outside the domain; qualified by out_valid.

Function
REQ-010 Pipeline SHALL be 4 stages: S1 input register; S2 synchronous LUT read with sign and class registered alongside; S3 fixed-to-float result register; S4 output register.
REQ-011 A sample accepted on an edge with enable=1 and in_valid=1 SHALL appear with out_valid=1 after exactly 4 enabled edges, including the accepting edge; no gaps and no reordering.
REQ-012 in_valid=0 SHALL inject a bubble that propagates as out_valid=0; data is don't-care but SHALL NOT change domain_err from 0.
REQ-013 enable=0 SHALL hold all stage registers, out_valid, num_salida and domain_err unchanged, and in_valid SHALL be ignored.
REQ-014 Classification on |x| = num_entrada[17:0]: ZERO if exponent=0 (denormals flushed); NORMAL if 0<exponent<127; ONE if exponent=127 and mantissa=0; DOMAIN otherwise, including exponent=255.
REQ-015 NORMAL address SHALL be floor(|x|*1024): (1.mantissa) shifted right by 127-exponent, truncated to 10 bits; a result of 0 uses address 0.
REQ-016 Fixed-to-float on the 12-bit LUT word q (9 fractional bits): q=0 gives zero magnitude; otherwise, with p = leading-one index, exponent = 118+p, and mantissa = the 10 bits below the leading one, zero-padded and truncated.
REQ-017 Output sign SHALL equal the input sign for all classes (odd function; ZERO yields signed zero).
REQ-018 ONE SHALL yield signed infinity {sign, 8'hFF, 10'h000} with domain_err=0.
REQ-019 DOMAIN SHALL yield quiet NaN {sign, 8'hFF, 10'h200} with domain_err=1.
REQ-020 The LUT address SHALL be 0 for ZERO, ONE and DOMAIN classes; the LUT data SHALL be ignored for those classes.

Reset
REQ-021 reset=1 at an edge SHALL clear all valid flags, num_salida=19'h00000, out_valid=0 and domain_err=0, regardless of enable.
REQ-022 Samples in flight at reset SHALL be discarded and never emerge.
REQ-023 In-flight samples SHALL NOT be preserved across reset, and LUT contents SHALL NOT be affected by reset.
REQ-024 The first sample accepted after reset deasserts SHALL follow REQ-011 timing exactly.

Configuration
REQ-025 Macro ATANH_LINEAR_BYPASS_EN: when defined, NORMAL operands with exponent<122 (|x|<2^-5) SHALL output num_entrada unchanged (atanh(x)~x) at the same 4-cycle latency.
REQ-026 Without ATANH_LINEAR_BYPASS_EN, all NORMAL operands SHALL use the LUT path.

Verification
REQ-027 Test: x=0x1F800 (0.5) -> after 4 cycles out_valid=1, num_salida=0x1F864, domain_err=0.
REQ-028 Test: 0x1FC00 -> 0x3FC00; 0x5FC00 -> 0x7FC00; 0x20000 (2.0) -> 0x3FE00 with domain_err=1; 0x00000 -> 0x00000; 0x40000 -> 0x40000.
REQ-029 Test: 0x1DD00 (1.25*2^-8) -> 0x1DE00 without ATANH_LINEAR_BYPASS_EN; 0x1DD00 with it defined.
REQ-030 Test: back-to-back valid stream of 0x1F800 and 0x5F800 with enable toggled 1,0,0,1,... -> outputs 0x1F864 then 0x5F864, in order, held during enable=0.
REQ-031 Test: reset asserted one cycle after accepting 3 samples -> out_valid stays 0 for the next 6 cycles with in_valid=0 and num_salida=0.

Source files
------------

// File: rtl/atanh_bfloat19_pipe.sv
// atanh_bfloat19_pipe: 4-stage bfloat19 atanh built around a 1024-entry table indexed by floor(|x|*1024).
// Optional macro ATANH_LINEAR_BYPASS_EN returns tiny NORMAL operands (|x| < 2^-5) unchanged.
module atanh_bfloat19_pipe #(
    parameter LUT_FILE = "atanh_4.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [18:0] num_entrada,
    output logic        out_valid,
    output logic [18:0] num_salida,
    output logic        domain_err
);

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_ONE    = 2'd2,
        CLS_DOMAIN = 2'd3
    } cls_t;

    // Table entry i = round(atanh(i/1024) * 512); built at elaboration so it matches the LUT_FILE image.
    logic [11:0] rom_s [1024];
    for (genvar g = 0; g < 1024; g++) begin : g_rom
        localparam real         X = g / 1024.0;
        localparam real         A = 0.5 * $ln((1.0 + X) / (1.0 - X)) * 512.0;
        localparam int unsigned V = $rtoi(A + 0.5);
        assign rom_s[g] = V[11:0];
    end

    // Leading-one index of the table word; 0 when the word is zero.
    function automatic logic [3:0] lead_one(input logic [11:0] q);
        logic [3:0] p;
        p = 4'd0;
        for (int i = 0; i < 12; i++) begin
            p = q[i] ? 4'(i) : p;
        end
        return p;
    endfunction

    logic        s1_valid_r;
    logic [18:0] s1_x_r;
    cls_t        s1_cls_s;
    logic [9:0]  s1_addr_s;
    logic [7:0]  s1_shift_s;

    logic        s2_valid_r;
    logic        s2_sign_r;
    cls_t        s2_cls_r;
    logic [11:0] s2_q_r;

    logic [3:0]  lead_s;
    logic [11:0] norm_s;
    logic [18:0] s3_res_s;
    logic        s3_derr_s;
    logic        s3_valid_r;
    logic [18:0] s3_res_r;
    logic        s3_derr_r;

`ifdef ATANH_LINEAR_BYPASS_EN
    logic        s1_byp_s;
    logic        s2_byp_r;
    logic [18:0] s2_x_r;

    assign s1_byp_s = (s1_cls_s == CLS_NORMAL) && (s1_x_r[17:10] < 8'd122);
`endif

    // Classify |x| and form the table address (only NORMAL operands index the table).
    always_comb begin
        s1_cls_s   = CLS_DOMAIN;
        s1_addr_s  = 10'd0;
        s1_shift_s = 8'd127 - s1_x_r[17:10];
        if (s1_x_r[17:10] == 8'd0) begin
            s1_cls_s = CLS_ZERO;
        end else if (s1_x_r[17:10] < 8'd127) begin
            s1_cls_s = CLS_NORMAL;
        end else if (s1_x_r[17:0] == {8'd127, 10'd0}) begin
            s1_cls_s = CLS_ONE;
        end else begin
            s1_cls_s = CLS_DOMAIN;
        end
        if (s1_cls_s == CLS_NORMAL) begin
            s1_addr_s = 10'({1'b1, s1_x_r[9:0]} >> s1_shift_s);
        end else begin
            s1_addr_s = 10'd0;
        end
    end

    // Convert the 9-fraction-bit table word to bfloat19 and apply the special classes.
    always_comb begin
        lead_s    = lead_one(s2_q_r);
        norm_s    = s2_q_r << (4'd11 - lead_s);
        s3_res_s  = {s2_sign_r, 18'd0};
        s3_derr_s = 1'b0;
        case (s2_cls_r)
            CLS_ZERO: begin
                s3_res_s = {s2_sign_r, 18'd0};
            end
            CLS_NORMAL: begin
`ifdef ATANH_LINEAR_BYPASS_EN
                if (s2_byp_r) begin
                    s3_res_s = s2_x_r;
                end else if (s2_q_r == 12'd0) begin
`else
                if (s2_q_r == 12'd0) begin
`endif
                    s3_res_s = {s2_sign_r, 18'd0};
                end else begin
                    s3_res_s = {s2_sign_r, 8'd118 + {4'd0, lead_s}, 10'(norm_s >> 1)};
                end
            end
            CLS_ONE: begin
                s3_res_s = {s2_sign_r, 8'hFF, 10'h000};
            end
            CLS_DOMAIN: begin
                s3_res_s  = {s2_sign_r, 8'hFF, 10'h200};
                s3_derr_s = 1'b1;
            end
            default: begin
                s3_res_s  = {s2_sign_r, 8'hFF, 10'h200};
                s3_derr_s = 1'b1;
            end
        endcase
    end

    // Synchronous table read; the table itself is never touched by reset.
    always_ff @(posedge clk) begin
        if (enable) begin
            s2_q_r <= rom_s[s1_addr_s];
        end
    end

    // Pipeline and output registers: reset wins over enable, enable low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= 19'd0;
            s2_valid_r <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_cls_r   <= CLS_ZERO;
            s3_valid_r <= 1'b0;
            s3_res_r   <= 19'd0;
            s3_derr_r  <= 1'b0;
            out_valid  <= 1'b0;
            num_salida <= 19'd0;
            domain_err <= 1'b0;
`ifdef ATANH_LINEAR_BYPASS_EN
            s2_byp_r   <= 1'b0;
            s2_x_r     <= 19'd0;
`endif
        end else if (enable) begin
            s1_valid_r <= in_valid;
            s1_x_r     <= num_entrada;
            s2_valid_r <= s1_valid_r;
            s2_sign_r  <= s1_x_r[18];
            s2_cls_r   <= s1_cls_s;
            s3_valid_r <= s2_valid_r;
            s3_res_r   <= s3_res_s;
            s3_derr_r  <= s3_derr_s;
            out_valid  <= s3_valid_r;
            domain_err <= s3_valid_r & s3_derr_r;
            if (s3_valid_r) begin
                num_salida <= s3_res_r;
            end
`ifdef ATANH_LINEAR_BYPASS_EN
            s2_byp_r   <= s1_byp_s;
            s2_x_r     <= s1_x_r;
`endif
        end
    end

endmodule

// File: tb/tb_atanh_bfloat19_pipe.sv
// Bench for atanh_bfloat19_pipe: directed vectors, enable/reset sequences and a random stream,
// all checked against a real-arithmetic reference model behind a 4-enabled-edge latency queue.
module tb_atanh_bfloat19_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [18:0] num_entrada;
    logic        out_valid;
    logic [18:0] num_salida;
    logic        domain_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        v;
        logic [18:0] res;
        logic        derr;
    } ent_t;

    ent_t        pipe_q[$];
    logic        exp_valid = 1'b0;
    logic [18:0] exp_res   = 19'd0;
    logic        exp_derr  = 1'b0;

    atanh_bfloat19_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .num_entrada(num_entrada),
        .out_valid  (out_valid),
        .num_salida (num_salida),
        .domain_err (domain_err)
    );

    always #5 clk = ~clk;

    // Reference: {domain_err, result} straight from the math definition of the operator.
    function automatic logic [19:0] ref_atanh(input logic [18:0] x);
        logic s;
        int   e, m, addr, q, p, mant;
        real  absx, t;
        s = x[18];
        e = int'(x[17:10]);
        m = int'(x[9:0]);
        if (e == 0) return {1'b0, s, 18'd0};
        if (e == 127 && m == 0) return {1'b0, s, 8'hFF, 10'h000};
        if (e >= 127) return {1'b1, s, 8'hFF, 10'h200};
`ifdef ATANH_LINEAR_BYPASS_EN
        if (e < 122) return {1'b0, x};
`endif
        absx = (1.0 + real'(m) / 1024.0) * (2.0 ** real'(e - 127));
        addr = $rtoi(absx * 1024.0);
        t    = real'(addr) / 1024.0;
        q    = $rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) * 512.0 + 0.5);
        if (q == 0) return {1'b0, s, 18'd0};
        p = 0;
        while ((q >> (p + 1)) != 0) p++;
        mant = $rtoi((real'(q) / (2.0 ** real'(p)) - 1.0) * 1024.0);
        return {1'b0, s, 8'(118 + p), 10'(mant)};
    endfunction

    function automatic logic [18:0] rand_x();
        logic [7:0] e;
        logic [9:0] m;
        m = 10'($urandom);
        case ($urandom_range(0, 5))
            0: e = 8'd0;
            1: begin
                e = 8'd127;
                if ($urandom_range(0, 1) == 0) m = 10'd0;
            end
            2: e = 8'($urandom_range(128, 255));
            3: e = 8'($urandom_range(100, 121));
            default: e = 8'($urandom_range(115, 126));
        endcase
        return {1'($urandom), e, m};
    endfunction

    task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%05h expected 0x%05h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, then compare 1 time unit later.
    task automatic cycle(input logic rst, input logic en, input logic v, input logic [18:0] x);
        ent_t        e_new;
        ent_t        e_out;
        logic [19:0] r;
        reset = rst; enable = en; in_valid = v; num_entrada = x;
        @(posedge clk);
        if (rst) begin
            pipe_q.delete();
            exp_valid = 1'b0; exp_res = 19'd0; exp_derr = 1'b0;
        end else if (en) begin
            r = ref_atanh(x);
            e_new.v = v; e_new.res = r[18:0]; e_new.derr = r[19];
            pipe_q.push_back(e_new);
            if (pipe_q.size() > 3) begin
                e_out     = pipe_q.pop_front();
                exp_valid = e_out.v;
                exp_derr  = e_out.v & e_out.derr;
                if (e_out.v) exp_res = e_out.res;
            end
        end
        #1;
        chk("out_valid", {18'd0, out_valid}, {18'd0, exp_valid});
        chk("domain_err", {18'd0, domain_err}, {18'd0, exp_derr});
        if (exp_valid || rst) chk("num_salida", num_salida, exp_res);
    endtask

    task automatic directed(input logic [18:0] x, input logic [18:0] want, input logic want_err);
        cycle(1'b0, 1'b1, 1'b1, x);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 19'd0);
        chk("dir_valid", {18'd0, out_valid}, 19'd1);
        chk("dir_result", num_salida, want);
        chk("dir_err", {18'd0, domain_err}, {18'd0, want_err});
    endtask

    initial begin
        logic [18:0] alt;
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 19'd0);

        directed(19'h1F800, 19'h1F864, 1'b0);
        directed(19'h1FC00, 19'h3FC00, 1'b0);
        directed(19'h5FC00, 19'h7FC00, 1'b0);
        directed(19'h20000, 19'h3FE00, 1'b1);
        directed(19'h00000, 19'h00000, 1'b0);
        directed(19'h40000, 19'h40000, 1'b0);
`ifdef ATANH_LINEAR_BYPASS_EN
        directed(19'h1DD00, 19'h1DD00, 1'b0);
`else
        directed(19'h1DD00, 19'h1DE00, 1'b0);
`endif

        // Valid stream with a gated enable; held outputs are checked every cycle.
        alt = 19'h1F800;
        for (int i = 0; i < 24; i++) begin
            cycle(1'b0, (i % 3) == 0, 1'b1, alt);
            if ((i % 3) == 0) alt = (alt == 19'h1F800) ? 19'h5F800 : 19'h1F800;
        end
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 19'd0);

        // Reset (with enable low) right after three accepted samples discards them.
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 19'h1F800);
        cycle(1'b1, 1'b0, 1'b1, 19'h1F800);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 19'h2A5A5);
            chk("post_reset_valid", {18'd0, out_valid}, 19'd0);
            chk("post_reset_data", num_salida, 19'd0);
        end
        directed(19'h5F800, 19'h5F864, 1'b0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 3) != 0, rand_x());
        end
        repeat (6) cycle(1'b0, 1'b1, 1'b0, 19'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
